imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time program loader upstream of the instruction memory. Receives a byte stream
//   (valid/ready) carrying a word count, little-endian 32-bit instruction words and a
//   checksum. Writes each assembled word into the instruction memory write port.
//   Holds the single-cycle core in reset until the image is loaded and verified.
// PARAMETERS
//   ADDR_W  8  instruction-memory word-address width; capacity = 2**ADDR_W words
// PORTS
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous, active-low reset
//   rx_valid     in   1         rx_data holds a byte
//   rx_ready     out  1         loader can accept a byte
//   rx_data      in   8         stream byte
//   imem_we      out  1         one-cycle instruction-memory write strobe
//   imem_waddr   out  ADDR_W    word address (the core fetches at pc>>2)
//   imem_wdata   out  32        assembled instruction word
//   core_rst_n   out  1         low = core held in reset; high only in DONE
//   done         out  1         image loaded and checksum good
//   error        out  1         load aborted (oversize or bad checksum)
//   word_count   out  ADDR_W+1  number of words written so far
// BEHAVIOUR
//   Reset (rst=0, async): state=HDR_LO, rx_ready=0 for the reset cycle,
//     imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, done=0, error=0,
//     word_count=0, byte index=0, sum=0.
//     rx_ready goes to 1 on the first clk edge after release.
//   Handshake: a byte is accepted on an edge where rx_valid&rx_ready=1.
//     rx_ready=1 in HDR_LO, HDR_HI, LOAD and CHECK; 0 in DONE and ERR.
//     rx_valid gaps are legal; state holds.
//   Stream format: N[7:0], N[15:8], then N words of 4 bytes each (LSB first), then CK.
//   Checksum: sum = 8-bit wraparound sum of every accepted byte, header and CK included.
//     The image is valid iff sum==8'h00 after CK is accepted.
//   FSM:
//     HDR_LO -> HDR_HI after accepting the low byte of N.
//     HDR_HI -> ERR if N > 2**ADDR_W.
//     HDR_HI -> CHECK if N==0.
//     HDR_HI -> LOAD otherwise.
//     LOAD   assembles bytes into word[8*k+:8] for k=0..3.
//       On the 4th byte: the word and address are registered, and imem_we=1
//         for exactly the next cycle (latency 1 cycle).
//       imem_waddr = word index (0..N-1). word_count increments with imem_we.
//       After word N-1 is accepted -> CHECK.
//     CHECK  accepts one byte (CK). sum==0 -> DONE, else -> ERR.
//     DONE   terminal: done=1, core_rst_n=1, rx_ready=0. Extra bytes are ignored.
//     ERR    terminal: error=1, core_rst_n=0, rx_ready=0. Left only by rst.
//   done and error are never both 1. imem_we is never asserted outside LOAD/CHECK
//     (the last write strobe may fall in the first CHECK cycle).
//   N == 2**ADDR_W is legal. imem_waddr reaches all-ones and does not wrap.
//   Reset mid-load: all state clears immediately. Partially written memory contents are
//     not erased. A fresh stream must restart from HDR_LO.
//   imem_wdata/imem_waddr hold their last values when imem_we=0.
// TESTING
//   1 Reset: assert rst=0 mid-cycle -> all outputs 0 and core_rst_n=0 asynchronously.
//     After release, rx_ready=1 in the next cycle.
//   2 Load (ADDR_W=8): bytes 02 00 93 00 50 00 13 01 A0 00 67 ->
//     write addr0=32'h00500093, then addr1=32'h00A00113, each one cycle after its 4th byte.
//     Then done=1, core_rst_n=1, word_count=2, rx_ready=0.
//   3 Empty image: bytes 00 00 00 -> no imem_we pulses, done=1, word_count=0.
//   4 Oversize: bytes 01 01 (N=257) -> error=1 after the 2nd byte, rx_ready=0, core_rst_n=0.
//     Further bytes are ignored.
//   5 Bad checksum: stream from test 2 with CK=68 -> both writes occur, error=1, done=0,
//     core_rst_n stays 0.
//   6 Throttling/reset: test 2 with random rx_valid gaps gives the identical write sequence.
//     Pulling rst low after 5 bytes, then resending the full stream -> done=1 and correct
//     words at addr0/1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Holds the core in reset until a checksummed image has been written.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal word count: a full memory.
    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

    state_t          state;
    logic [7:0]      n_lo;
    logic [ADDR_W:0] n_words;
    logic [7:0]      sum;
    logic [1:0]      k;
    logic [23:0]     wbuf;

    logic            accept;
    logic [16:0]     n_hdr;
    logic [7:0]      sum_nx;
    logic [ADDR_W:0] count_nx;

    // Handshake, header value, running checksum and next word count.
    always_comb begin
        accept   = rx_valid & rx_ready;
        n_hdr    = {1'b0, rx_data, n_lo};
        sum_nx   = sum + rx_data;
        count_nx = word_count + 1'b1;
    end

    // Loader FSM; every output is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_HDR_LO;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            n_lo       <= '0;
            n_words    <= '0;
            sum        <= '0;
            k          <= '0;
            wbuf       <= '0;
        end else begin
            imem_we <= 1'b0;
            // ready rises on the first edge after reset release
            if (state == S_HDR_LO && !rx_ready) begin
                rx_ready <= 1'b1;
            end
            if (accept) begin
                sum <= sum_nx;
                case (state)
                    S_HDR_LO: begin
                        n_lo  <= rx_data;
                        state <= S_HDR_HI;
                    end
                    S_HDR_HI: begin
                        if (n_hdr > CAP) begin
                            state    <= S_ERR;
                            error    <= 1'b1;
                            rx_ready <= 1'b0;
                        end else if (n_hdr == 17'd0) begin
                            state <= S_CHECK;
                        end else begin
                            n_words <= n_hdr[ADDR_W:0];
                            state   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        k <= k + 2'd1;
                        if (k == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_data, wbuf};
                            imem_waddr <= word_count[ADDR_W-1:0];
                            word_count <= count_nx;
                            if (count_nx == n_words) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            wbuf[8*k +: 8] <= rx_data;
                        end
                    end
                    S_CHECK: begin
                        rx_ready <= 1'b0;
                        if (sum_nx == 8'h00) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, corner sequences and randomized
// images checked against a stream-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_data = 8'h00;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .done(done),
        .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]  sq[$];
    logic [39:0] wq[$];
    logic [39:0] ew[$];
    bit exp_done;
    bit exp_err;
    int exp_cnt;
    bit acc_prev = 1'b0;

    typedef struct {
        logic [7:0]  b[12];
        int          len;
        bit          d;
        bit          e;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(posedge clk) acc_prev <= rx_valid && rx_ready;

    // Capture writes; each must follow an accepted byte by one cycle.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            wq.push_back({imem_waddr, imem_wdata});
            total++;
            if (!acc_prev) begin
                bad++;
                $display("FAIL we_latency actual=0 required=1");
            end
        end
        if (done && error) begin
            total++;
            bad++;
            $display("FAIL done_and_error actual=1 required=0");
        end
    end

    // Reference model: derive outcome of stream sq from the format rules.
    function automatic void model();
        int n;
        int s;
        logic [7:0]  a;
        logic [31:0] w;
        ew.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        n = sq[0] + 256 * sq[1];
        if (n > 256) begin
            exp_err = 1'b1;
            return;
        end
        s = 0;
        for (int i = 0; i < 2 + 4 * n + 1; i++) s += sq[i];
        for (int j = 0; j < n; j++) begin
            a = j[7:0];
            w = {sq[5+4*j], sq[4+4*j], sq[3+4*j], sq[2+4*j]};
            ew.push_back({a, w});
        end
        exp_cnt = n;
        if (s % 256 == 0) exp_done = 1'b1;
        else exp_err = 1'b1;
    endfunction

    function automatic void gen_stream(input int n, input bit good);
        int s;
        logic [7:0] b;
        logic [7:0] ck;
        sq.delete();
        sq.push_back(n[7:0]);
        sq.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            sq.push_back(b);
        end
        s = 0;
        foreach (sq[i]) s += sq[i];
        ck = 8'(256 - (s % 256));
        if (!good) ck = ck + 8'($urandom_range(1, 255));
        sq.push_back(ck);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last,
                              input int maxgap);
        for (int i = first; i < last; i++)
            send_byte(sq[i], $urandom_range(0, maxgap));
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wq.delete();
        @(negedge clk);
    endtask

    task automatic check_run(input string nm);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({nm, " nwrites"}, 64'(wq.size()), 64'(ew.size()));
        for (int i = 0; i < wq.size() && i < ew.size(); i++)
            chk({nm, " write"}, 64'(wq[i]), 64'(ew[i]));
        chk({nm, " done"}, 64'(done), 64'(exp_done));
        chk({nm, " error"}, 64'(error), 64'(exp_err));
        chk({nm, " core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
        chk({nm, " rx_ready"}, 64'(rx_ready), 64'(0));
        chk({nm, " word_count"}, 64'(word_count), 64'(exp_cnt));
    endtask

    task automatic mid_reset_check();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst imem_we", 64'(imem_we), 64'(0));
        chk("rst imem_waddr", 64'(imem_waddr), 64'(0));
        chk("rst imem_wdata", 64'(imem_wdata), 64'(0));
        chk("rst core_rst_n", 64'(core_rst_n), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst error", 64'(error), 64'(0));
        chk("rst word_count", 64'(word_count), 64'(0));
        chk("rst rx_ready", 64'(rx_ready), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        wq.delete();
        #1 chk("release rx_ready low", 64'(rx_ready), 64'(0));
        @(negedge clk);
        chk("release rx_ready high", 64'(rx_ready), 64'(1));
    endtask

    function automatic void load_t2();
        sq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00, 8'h67};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0].b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                    8'h13, 8'h01, 8'hA0, 8'h00, 8'h67, 8'h11};
        vt[0].len = 12; vt[0].d = 1; vt[0].e = 0; vt[0].nw = 2;
        vt[0].w0 = 32'h00500093; vt[0].w1 = 32'h00A00113;
        vt[1].b = '{8'h00, 8'h00, 8'h00, 8'h55, 8'h0, 8'h0,
                    8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        vt[1].len = 4; vt[1].d = 1; vt[1].e = 0; vt[1].nw = 0;
        vt[1].w0 = 32'h0; vt[1].w1 = 32'h0;
        vt[2].b = '{8'h01, 8'h01, 8'h13, 8'h93, 8'h00, 8'h0,
                    8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        vt[2].len = 5; vt[2].d = 0; vt[2].e = 1; vt[2].nw = 0;
        vt[2].w0 = 32'h0; vt[2].w1 = 32'h0;
        vt[3].b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                    8'h13, 8'h01, 8'hA0, 8'h00, 8'h68, 8'h0};
        vt[3].len = 11; vt[3].d = 0; vt[3].e = 1; vt[3].nw = 2;
        vt[3].w0 = 32'h00500093; vt[3].w1 = 32'h00A00113;

        // Reset state while held in reset.
        @(negedge clk);
        chk("init rx_ready", 64'(rx_ready), 64'(0));
        chk("init core_rst_n", 64'(core_rst_n), 64'(0));
        do_reset();
        chk("post-reset rx_ready", 64'(rx_ready), 64'(1));

        // Table vectors.
        foreach (vt[v]) begin
            do_reset();
            for (int i = 0; i < vt[v].len; i++) send_byte(vt[v].b[i], 0);
            ew.delete();
            if (vt[v].nw > 0) ew.push_back({8'h00, vt[v].w0});
            if (vt[v].nw > 1) ew.push_back({8'h01, vt[v].w1});
            exp_done = vt[v].d;
            exp_err  = vt[v].e;
            exp_cnt  = vt[v].nw;
            check_run($sformatf("vec%0d", v));
        end

        // Oversize: error right after the second header byte.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("oversize error", 64'(error), 64'(1));
        chk("oversize rx_ready", 64'(rx_ready), 64'(0));

        // Async reset mid-word, then full reload.
        do_reset();
        load_t2();
        send_range(0, 7, 0);
        mid_reset_check();
        send_range(0, sq.size(), 0);
        model();
        check_run("reset7 reload");

        // Reset after 5 bytes, then throttled reload.
        do_reset();
        load_t2();
        send_range(0, 5, 2);
        do_reset();
        send_range(0, sq.size(), 3);
        model();
        check_run("reset5 reload");

        // Full-capacity image: addresses reach 255 without wrapping.
        do_reset();
        gen_stream(256, 1'b1);
        send_range(0, sq.size(), 0);
        model();
        check_run("n256");

        // Just over capacity.
        do_reset();
        gen_stream(257, 1'b1);
        send_range(0, 6, 0);
        model();
        check_run("n257");

        // Randomized images with random gaps.
        for (int r = 0; r < 40; r++) begin
            do_reset();
            if (r % 10 == 9) begin
                sq.delete();
                sq.push_back(8'($urandom));
                sq.push_back(8'($urandom_range(2, 255)));
                sq.push_back(8'($urandom));
                sq.push_back(8'($urandom));
            end else begin
                gen_stream($urandom_range(0, 6), ($urandom_range(0, 3) != 0));
                if (r % 4 == 0) sq.push_back(8'($urandom));
            end
            send_range(0, sq.size(), $urandom_range(0, 3));
            model();
            check_run($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
